column_feeder: RTL and testbench

//  Upstream stage of column_serial. Accepts packed words of PACK pixels over a valid/ready

---
 rtl/column_feeder.sv | 154 +++++++++++++++
 tb/tb_column_feeder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/column_feeder.sv
// rtl/column_feeder.sv - serialises packed pixel words into the column buffer write port
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   packed input word valid
//   in_data    PACK pixels, lane 0 in the low DATA_WIDTH bits
//   in_ready   word accepted when in_valid & in_ready
//   wr_req_p   pixel write strobe to column_serial
//   wr_data_p  pixel written with wr_req_p
//   rd_req_p   copy of the consumer's read strobe
//   level      pixels written and not yet read (0..DEPTH)
//   col_done   pulses together with the last pixel write of a column
//   err_udf    sticky: read seen while level was 0
module column_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int PACK       = 4,
    parameter int COL_LEN    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [PACK*DATA_WIDTH-1:0]   in_data,
    output logic                         in_ready,
    output logic                         wr_req_p,
    output logic [DATA_WIDTH-1:0]        wr_data_p,
    input  logic                         rd_req_p,
    output logic [ADDR_WIDTH:0]          level,
    output logic                         col_done,
    output logic                         err_udf
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PW    = $clog2(PACK + 1);
    localparam int LVW   = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                      state_q, state_d;
    logic [PACK*DATA_WIDTH-1:0]  shreg_q, shreg_d;
    logic [PW-1:0]               pending_q, pending_d;
    logic [LW-1:0]               lane_q, lane_d;
    logic [ADDR_WIDTH:0]         level_q, level_d;
    logic [15:0]                 col_cnt_q, col_cnt_d;
    logic                        wr_req_q, wr_req_d;
    logic [DATA_WIDTH-1:0]       wr_data_q, wr_data_d;
    logic                        col_done_q, col_done_d;
    logic                        err_udf_q, err_udf_d;

    logic                        accept;
    logic [DATA_WIDTH-1:0]       lane_pix;
    logic [LVW-1:0]              lvl_sum;

    always_comb begin
        // Budget counts the word still being shifted so level can never exceed DEPTH,
        // even if the consumer stops reading.
        in_ready = reset && (pending_q <= PW'(1)) &&
                   (({1'b0, level_q} + LVW'(pending_q) + LVW'(PACK)) <= LVW'(DEPTH));
        accept   = in_valid && in_ready;

        lane_pix = '0;
        for (int i = 0; i < PACK; i++) begin
            if (LW'(i) == lane_q) begin
                lane_pix = shreg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        state_d    = state_q;
        shreg_d    = shreg_q;
        pending_d  = pending_q;
        lane_d     = lane_q;
        wr_req_d   = 1'b0;
        wr_data_d  = wr_data_q;
        col_cnt_d  = col_cnt_q;
        col_done_d = 1'b0;
        err_udf_d  = err_udf_q;

        if (state_q == SHIFT && pending_q != '0) begin
            wr_req_d  = 1'b1;
            wr_data_d = lane_pix;
            lane_d    = lane_q + LW'(1);
            pending_d = pending_q - PW'(1);
        end

        // An accept while the last lane goes out overrides the countdown, giving
        // gap-free back-to-back words.
        if (accept) begin
            shreg_d   = in_data;
            pending_d = PW'(PACK);
            lane_d    = '0;
            state_d   = SHIFT;
        end else if (pending_d == '0) begin
            state_d = IDLE;
        end

        // level tracks the strobe being presented, so it rises with wr_req_p.
        lvl_sum = {1'b0, level_q} + LVW'(wr_req_d);
        if (rd_req_p) begin
            if (level_q != '0) begin
                lvl_sum = lvl_sum - LVW'(1);
            end else begin
                err_udf_d = 1'b1;
            end
        end
        level_d = lvl_sum[ADDR_WIDTH:0];

        if (wr_req_d) begin
            if (col_cnt_q == 16'(COL_LEN - 1)) begin
                col_cnt_d  = '0;
                col_done_d = 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            pending_q  <= '0;
            lane_q     <= '0;
            level_q    <= '0;
            col_cnt_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_data_q  <= '0;
            col_done_q <= 1'b0;
            err_udf_q  <= 1'b0;
        end else begin
            assert (!(wr_req_d && level_q == FULL))
                else $error("column_feeder: write issued with buffer full");
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pending_q  <= pending_d;
            lane_q     <= lane_d;
            level_q    <= level_d;
            col_cnt_q  <= col_cnt_d;
            wr_req_q   <= wr_req_d;
            wr_data_q  <= wr_data_d;
            col_done_q <= col_done_d;
            err_udf_q  <= err_udf_d;
        end
    end

    assign wr_req_p  = wr_req_q;
    assign wr_data_p = wr_data_q;
    assign level     = level_q;
    assign col_done  = col_done_q;
    assign err_udf   = err_udf_q;

endmodule

// File: tb/tb_column_feeder.sv
// tb/tb_column_feeder.sv - self-checking bench for column_feeder against a pixel-queue model
module tb_column_feeder;

    localparam int DW      = 8;
    localparam int AW      = 6;
    localparam int PACK    = 4;
    localparam int COL_LEN = 32;
    localparam int DEPTH   = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [PACK*DW-1:0] in_data = '0;
    logic              in_ready;
    logic              wr_req_p;
    logic [DW-1:0]     wr_data_p;
    logic              rd_req_p = 1'b0;
    logic [AW:0]       level;
    logic              col_done;
    logic              err_udf;

    column_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PACK(PACK), .COL_LEN(COL_LEN)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_req_p(wr_req_p), .wr_data_p(wr_data_p),
        .rd_req_p(rd_req_p), .level(level), .col_done(col_done), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: pixels accepted but not yet strobed, occupancy, pixel count, sticky error.
    logic [DW-1:0] q[$];
    int  m_level = 0;
    int  m_cnt   = 0;
    bit  m_err   = 0;
    int  n_acc   = 0;
    int  n_done  = 0;
    int  max_lvl = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit rn, input bit v, input logic [PACK*DW-1:0] d, input bit rd);
        bit exp_ready;
        bit acc;
        bit w;
        logic [DW-1:0] px;
        reset    = rn;
        in_valid = v;
        in_data  = d;
        rd_req_p = rd;
        @(negedge clk);
        exp_ready = rn && (q.size() <= 1) && (m_level + q.size() + PACK <= DEPTH);
        chk("in_ready", in_ready, exp_ready);
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        if (!rn) begin
            q.delete();
            m_level = 0;
            m_cnt   = 0;
            m_err   = 0;
            chk("rst_wr_req", wr_req_p, 0);
            chk("rst_wr_data", wr_data_p, 0);
            chk("rst_level", level, 0);
            chk("rst_col_done", col_done, 0);
            chk("rst_err_udf", err_udf, 0);
            return;
        end
        w = (q.size() > 0);
        chk("wr_req", wr_req_p, w);
        if (w) begin
            px = q.pop_front();
            chk("wr_data", wr_data_p, px);
            m_cnt++;
        end
        chk("col_done", col_done, w && (m_cnt % COL_LEN == 0));
        if (rd && m_level == 0) m_err = 1;
        m_level = m_level + int'(w) - ((rd && m_level > 0) ? 1 : 0);
        chk("level", level, m_level);
        chk("err_udf", err_udf, m_err);
        if (acc) begin
            for (int i = 0; i < PACK; i++) q.push_back(d[i*DW +: DW]);
            n_acc++;
        end
        if (col_done === 1'b1) n_done++;
        if (int'(level) > max_lvl) max_lvl = int'(level);
    endtask

    initial begin
        bit once;
        bit rv;
        bit rr;
        bit rn;

        // Reset state
        step(0, 0, '0, 0);
        step(0, 1, 32'hdeadbeef, 0);

        // 1: single word, lanes LSB first
        step(1, 1, 32'h44332211, 0);
        repeat (6) step(1, 0, '0, 0);
        chk("t1_level", level, 4);
        chk("t1_in_ready", in_ready, 1);

        // 2: hold valid without reads until full, then free one word of space
        step(0, 0, '0, 0);
        n_acc = 0;
        repeat (80) step(1, 1, $urandom, 0);
        chk("t2_accepts", n_acc, 16);
        chk("t2_level_full", level, 64);
        repeat (4) step(1, 1, $urandom, 1);
        repeat (3) step(1, 1, $urandom, 0);
        chk("t2_accepts_after_reads", n_acc, 17);

        // 3: streaming with a read every cycle after the first write
        step(0, 0, '0, 0);
        n_acc = 0; n_done = 0; max_lvl = 0;
        repeat (40) step(1, n_acc < 8, $urandom, m_level > 0);
        chk("t3_col_done_pulses", n_done, 1);
        chk("t3_max_level", max_lvl, 1);
        chk("t3_accepts", n_acc, 8);

        // 4: underflow is sticky until reset
        step(0, 0, '0, 0);
        step(1, 0, '0, 1);
        chk("t4_err", err_udf, 1);
        chk("t4_level", level, 0);
        repeat (5) step(1, 0, '0, 0);
        chk("t4_err_held", err_udf, 1);
        step(0, 0, '0, 0);
        chk("t4_err_cleared", err_udf, 0);

        // 5: reset after two of four lanes, then a fresh column
        step(1, 1, 32'haabbccdd, 0);
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        chk("t5_level_mid", level, 2);
        step(0, 0, '0, 0);
        repeat (3) step(1, 0, '0, 0);
        chk("t5_no_writes", wr_req_p, 0);
        n_acc = 0; n_done = 0;
        repeat (40) step(1, n_acc < 8, $urandom, 0);
        chk("t5_col_done_pulses", n_done, 1);
        chk("t5_level", level, 32);

        // 6: write and read together at DEPTH-1
        step(0, 0, '0, 0);
        once = 0;
        repeat (80) begin
            rr = (m_level == DEPTH - 1) && (q.size() > 0) && !once;
            if (rr) once = 1;
            step(1, 1, $urandom, rr);
        end
        chk("t6_level", level, DEPTH - 1);

        // 7: random traffic with occasional resets
        step(0, 0, '0, 0);
        repeat (1500) begin
            rn = ($urandom % 100) != 0;
            rv = ($urandom % 2) == 0;
            rr = ($urandom % 100) < 45;
            step(rn, rv, $urandom, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
